// File: rtl/ddr_wr_arbiter.sv
// ddr_wr_arbiter: round-robin sharing of the DDR user write port among NREQ DMA write masters
module ddr_wr_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = 32
) (
  input  logic              i_sys_clk,
  input  logic              i_reset_n,
  input  logic [NREQ-1:0]   i_wr_req,
  input  logic [NREQ*32-1:0] i_wr_addr,
  input  logic [NREQ*32-1:0] i_wr_len,
  input  logic [NREQ*DW-1:0] i_wr_data,
  input  logic [NREQ-1:0]   i_wr_data_ready,
  output logic [NREQ-1:0]   o_wr_ack,
  output logic [NREQ-1:0]   o_wr_data_req,
  output logic [NREQ-1:0]   o_wr_req_done,
  output logic              o_ddr_wr_req,
  output logic [31:0]       o_ddr_wr_addr,
  output logic [31:0]       o_ddr_wr_len,
  output logic [DW-1:0]     o_ddr_wr_data,
  output logic              o_ddr_wr_data_ready,
  input  logic              i_ddr_wr_ack,
  input  logic              i_ddr_wr_data_req,
  input  logic              i_ddr_wr_req_done,
  output logic [NREQ-1:0]   o_gnt,
  output logic              o_busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
  state_t state;
  logic [IW-1:0] last_gnt, win, idx;
  logic [31:0] win_addr, win_len;
  // scan from farthest to nearest so the master right after last_gnt wins
  always_comb begin
    win = last_gnt;
    idx = last_gnt;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IW'((int'(last_gnt) + i) % NREQ);
      win = i_wr_req[idx] ? idx : win;
    end
  end
  assign win_addr = i_wr_addr[32*win +: 32];
  assign win_len  = i_wr_len[32*win +: 32];
  always_comb begin
    o_ddr_wr_data = '0;
    o_ddr_wr_data_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      o_ddr_wr_data = o_ddr_wr_data | (i_wr_data[k*DW +: DW] & {DW{o_gnt[k]}});
      o_ddr_wr_data_ready = o_ddr_wr_data_ready | (i_wr_data_ready[k] & o_gnt[k]);
    end
  end
  assign o_wr_ack      = o_gnt & {NREQ{(state == REQ && i_ddr_wr_ack) || state == DONE}};
  assign o_wr_data_req = o_gnt & {NREQ{state == XFER && i_ddr_wr_data_req}};
  assign o_wr_req_done = o_gnt & {NREQ{(state == XFER && i_ddr_wr_req_done) || state == DONE}};
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      o_gnt <= '0;
      last_gnt <= IW'(NREQ - 1);
      o_ddr_wr_addr <= '0;
      o_ddr_wr_len <= '0;
      o_ddr_wr_req <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|i_wr_req) begin
          o_gnt <= NREQ'(1) << win;
          last_gnt <= win;
          o_ddr_wr_addr <= win_addr;
          o_ddr_wr_len <= win_len;
          o_busy <= 1'b1;
          o_ddr_wr_req <= win_len != 0;
          state <= (win_len != 0) ? REQ : DONE;
        end
        REQ: if (i_ddr_wr_ack) begin
          o_ddr_wr_req <= 1'b0;
          state <= XFER;
        end
        XFER: if (i_ddr_wr_req_done) begin
          o_gnt <= '0;
          o_busy <= 1'b0;
          state <= IDLE;
        end
        DONE: begin
          o_gnt <= '0;
          o_busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/ddr_wr_arbiter.md
# ddr_wr_arbiter

Round-robin arbiter that shares the single DDR user write port (req/ack/addr/len/data_req/data_ready/req_done handshake of the DDR wrapper) among NREQ DMA write masters, e.g. the UART DMA and the Ethernet DMA. It runs in the DDR ui_clk domain between the DMA engines and the DDR wrapper. It grants one master per burst, routes the command and data paths to that master, and completes zero-length bursts locally without touching DDR.

## Interface
- NREQ, 2: number of write masters, 2..4.
- DW, 32: data word width.
- i_sys_clk  in  1  clock (DDR ui_clk).
- i_reset_n  in  1  asynchronous active-low reset.
- i_wr_req  in  NREQ  per-master burst request, held until its o_wr_ack.
- i_wr_addr  in  NREQ*32  packed start addresses, master k at [32k+31:32k].
- i_wr_len  in  NREQ*32  packed burst lengths in words.
- i_wr_data  in  NREQ*DW  packed write data.
- i_wr_data_ready  in  NREQ  master has a valid word on its data slice.
- o_wr_ack  out  NREQ  one-cycle command accept pulse.
- o_wr_data_req  out  NREQ  word consumed this cycle; master must advance.
- o_wr_req_done  out  NREQ  one-cycle burst-complete pulse.
- o_ddr_wr_req  out  1  request to DDR port.
- o_ddr_wr_addr  out  32  registered address of granted master.
- o_ddr_wr_len  out  32  registered length of granted master.
- o_ddr_wr_data  out  DW  data of granted master (combinational mux).
- o_ddr_wr_data_ready  out  1  i_wr_data_ready of granted master, 0 when no grant.
- i_ddr_wr_ack  in  1  DDR command accept pulse.
- i_ddr_wr_data_req  in  1  DDR consumes o_ddr_wr_data this cycle.
- i_ddr_wr_req_done  in  1  DDR burst complete pulse.
- o_gnt  out  NREQ  one-hot current owner, 0 when idle.
- o_busy  out  1  state != IDLE.

## Operation
- FSM: IDLE, REQ, XFER, DONE.
- IDLE: if any i_wr_req, pick the winner by round-robin and register gnt, addr and len. Search starts at last_gnt+1 modulo NREQ. If winner len != 0, go to REQ. If len == 0, go to DONE (local completion). Else stay.
- REQ: o_ddr_wr_req=1. On i_ddr_wr_ack, pulse o_wr_ack[g] in the same cycle (combinational gate) and go to XFER.
- XFER: route i_ddr_wr_data_req to o_wr_data_req[g], i_wr_data[g] to o_ddr_wr_data, and i_wr_data_ready[g] to o_ddr_wr_data_ready. On i_ddr_wr_req_done, pulse o_wr_req_done[g] and go to IDLE, clearing o_gnt.
- DONE (len==0 only): pulse o_wr_ack[g] and o_wr_req_done[g] together for one cycle, then go to IDLE.
- last_gnt updates at every grant. Reset value is NREQ-1, so master 0 wins first.
- Stray inputs are ignored: i_ddr_wr_ack outside REQ, and i_ddr_wr_data_req or i_ddr_wr_req_done outside XFER.
- Non-granted masters see o_wr_ack, o_wr_data_req and o_wr_req_done all 0, regardless of DDR activity.
- A master deasserting i_wr_req before its ack violates protocol. The arbiter does not abort and keeps the burst.
- If i_ddr_wr_ack and i_ddr_wr_req_done arrive in the same cycle in REQ, only the ack is honoured.

## Timing
- Reset (asynchronous): state IDLE; o_gnt=0, o_busy=0, o_ddr_wr_req=0, o_ddr_wr_addr=0, o_ddr_wr_len=0. All per-master pulses are 0. o_ddr_wr_data=0 and o_ddr_wr_data_ready=0 because nothing is granted.
- Reset mid-burst drops o_ddr_wr_req and the grant immediately. The DDR side is reset in parallel by the system.
- Command latency: i_wr_req high at cycle t in IDLE gives o_ddr_wr_req, o_gnt and o_busy high at t+1.
- Ack and done pulses are zero-latency pass-through of the DDR pulses.
- Back-to-back: done at cycle t returns to IDLE at t+1, and the next o_ddr_wr_req is high at t+2.
- Zero-length burst: request at t gives the ack/done pulse at t+1 and IDLE at t+2.
- Data path is purely combinational while in XFER; there is no buffering.

## Test plan
- Single master 0, addr=0x1000, len=4:
  - o_ddr_wr_req at t+1 with addr/len forwarded.
  - Ack passes to master 0 only.
  - 4 data_req pulses route data 0xA0..0xA3.
  - Done passes to master 0; busy drops the next cycle.
- Masters 0 and 1 request in the same cycle, each with len=2:
  - Master 0 is served first, then master 1.
  - Master 1's o_ddr_wr_req rises exactly 2 cycles after master 0's done.
- Both masters hold requests continuously for 6 bursts -> grant order 0,1,0,1,0,1.
- Master 1 requests with len=0 -> no o_ddr_wr_req, and o_wr_ack[1] and o_wr_req_done[1] pulse together at t+1.
- i_reset_n low in XFER after 2 of 8 words:
  - All outputs are 0 at once.
  - After release, a fresh request from master 1 is granted normally.
- Stray i_ddr_wr_req_done in IDLE and stray i_ddr_wr_ack in XFER -> no per-master pulse and no state change.
